// File: rtl/cheri_tsmap_arb_pkg.sv
// Shared types and helpers for the TS map SRAM arbiter.
package cheri_tsmap_arb_pkg;

    localparam int TSMAP_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        MERGE,
        WRITE,
        RESP
    } arb_state_e;

    // Per-byte select: bytes with be set come from new_word, the rest from old_word.
    function automatic logic [TSMAP_WORD_W-1:0] be_merge(
        input logic [TSMAP_WORD_W-1:0] old_word,
        input logic [TSMAP_WORD_W-1:0] new_word,
        input logic [3:0]              be
    );
        logic [TSMAP_WORD_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cheri_tsmap_arbiter.sv
// Shares the single-port TS map SRAM between the core's revocation read port
// (always wins) and a host port with read-modify-write for partial writes.
module cheri_tsmap_arbiter
    import cheri_tsmap_arb_pkg::*;
#(
    parameter int TSMapSize = 1024,
    parameter int AddrW     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    core_cs_i,
    input  logic [AddrW-1:0]        core_addr_i,
    output logic [TSMAP_WORD_W-1:0] core_rdata_o,
    input  logic                    host_req_i,
    input  logic                    host_we_i,
    input  logic [3:0]              host_be_i,
    input  logic [AddrW-1:0]        host_addr_i,
    input  logic [TSMAP_WORD_W-1:0] host_wdata_i,
    output logic                    host_gnt_o,
    output logic                    host_rvalid_o,
    output logic [TSMAP_WORD_W-1:0] host_rdata_o,
    output logic                    host_err_o,
    output logic                    ram_req_o,
    output logic                    ram_we_o,
    output logic [AddrW-1:0]        ram_addr_o,
    output logic [TSMAP_WORD_W-1:0] ram_wdata_o,
    input  logic [TSMAP_WORD_W-1:0] ram_rdata_i
);

    localparam logic [31:0] MAP_WORDS = 32'(TSMapSize);

    arb_state_e              state_q, state_d;
    logic [AddrW-1:0]        addr_q;
    logic [3:0]              be_q;
    logic [TSMAP_WORD_W-1:0] wdata_q;
    logic [TSMAP_WORD_W-1:0] merged_q;
    logic                    rd_q, rd_d;
    logic                    err_q, err_d;
    logic                    fwd_q;
    logic                    latch_en;
    logic                    out_of_range;
    logic                    host_ram_req;
    logic                    host_ram_we;
    logic [AddrW-1:0]        host_ram_addr;
    logic [TSMAP_WORD_W-1:0] host_ram_wdata;

    assign out_of_range = 32'(host_addr_i) >= MAP_WORDS;

    always_comb begin
        state_d        = state_q;
        host_gnt_o     = 1'b0;
        host_ram_req   = 1'b0;
        host_ram_we    = 1'b0;
        host_ram_addr  = host_addr_i;
        host_ram_wdata = host_wdata_i;
        latch_en       = 1'b0;
        rd_d           = rd_q;
        err_d          = err_q;
        unique case (state_q)
            IDLE: begin
                if (host_req_i && !rst_i) begin
                    if (out_of_range) begin
                        host_gnt_o = 1'b1;
                        err_d      = 1'b1;
                        rd_d       = 1'b0;
                        state_d    = RESP;
                    end else if (host_we_i && host_be_i == 4'b0000) begin
                        host_gnt_o = 1'b1;
                        err_d      = 1'b0;
                        rd_d       = 1'b0;
                        state_d    = RESP;
                    end else if (!core_cs_i) begin
                        host_gnt_o   = 1'b1;
                        host_ram_req = 1'b1;
                        err_d        = 1'b0;
                        rd_d         = !host_we_i;
                        if (!host_we_i) begin
                            state_d = RESP;
                        end else if (host_be_i == 4'b1111) begin
                            host_ram_we = 1'b1;
                            state_d     = RESP;
                        end else begin
                            latch_en = 1'b1;
                            state_d  = MERGE;
                        end
                    end
                end
            end
            MERGE: state_d = WRITE;
            WRITE: begin
                if (!core_cs_i && !rst_i) begin
                    host_ram_req   = 1'b1;
                    host_ram_we    = 1'b1;
                    host_ram_addr  = addr_q;
                    host_ram_wdata = merged_q;
                    state_d        = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Core access overrides whatever the host path requested this cycle.
    assign ram_req_o   = core_cs_i | host_ram_req;
    assign ram_we_o    = !core_cs_i & host_ram_we;
    assign ram_addr_o  = core_cs_i ? core_addr_i : host_ram_addr;
    assign ram_wdata_o = host_ram_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
            fwd_q    <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            fwd_q   <= (state_q == WRITE) && core_cs_i && (core_addr_i == addr_q);
            if (latch_en) begin
                addr_q  <= host_addr_i;
                be_q    <= host_be_i;
                wdata_q <= host_wdata_i;
            end
            if (state_q == MERGE) merged_q <= be_merge(ram_rdata_i, wdata_q, be_q);
        end
    end

    // Read data comes straight from the SRAM output in the response cycle.
    assign host_rvalid_o = (state_q == RESP);
    assign host_err_o    = host_rvalid_o & err_q;
    assign host_rdata_o  = (host_rvalid_o && rd_q) ? ram_rdata_i : '0;
    assign core_rdata_o  = fwd_q ? merged_q : ram_rdata_i;

endmodule
